// File: rtl/divisor_pkg.sv
// divisor_pkg
//   Shared types and default widths for the sequential restoring divider.
//   - state_t      : controller states (IDLE, RUN, DONE)
//   - DEF_DIVIDEND_W / DEF_DIVISOR_W : default operand widths
//   - cnt_width()  : step-counter width for a given dividend width
package divisor_pkg;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold DIVIDEND_W itself.
    function automatic int cnt_width(input int dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

endpackage

// File: rtl/div_paso.sv
// div_paso
//   One combinational restoring-division step.
//   Shifts {p_in, q_in} left by one, then subtracts the divisor from the
//   partial remainder if it fits, setting the new quotient LSB.
//   Ports:
//     p_in    [DIVISOR_W:0]    partial remainder before the step
//     q_in    [DIVIDEND_W-1:0] quotient/dividend shift register before the step
//     divisor [DIVISOR_W-1:0]  latched divisor
//     p_out   [DIVISOR_W:0]    partial remainder after the step
//     q_out   [DIVIDEND_W-1:0] shift register after the step
module div_paso
    import divisor_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]    p_in,
    input  logic [DIVIDEND_W-1:0] q_in,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVISOR_W:0]    p_out,
    output logic [DIVIDEND_W-1:0] q_out
);

    // Shifted remainder is kept one bit wider than P so the trial
    // subtraction's borrow lands in the MSB and doubles as the compare.
    logic [DIVISOR_W+1:0] p_sh;
    logic [DIVISOR_W+1:0] diff;
    logic                 fits;

    always_comb begin
        p_sh  = {p_in, q_in[DIVIDEND_W-1]};
        diff  = p_sh - {2'b00, divisor};
        fits  = ~diff[DIVISOR_W+1];
        p_out = fits ? diff[DIVISOR_W:0] : p_sh[DIVISOR_W:0];
        q_out = {q_in[DIVIDEND_W-2:0], fits};
    end

endmodule

// File: rtl/divisor_secuencial.sv
// divisor_secuencial
//   Multi-cycle unsigned restoring divider, one quotient bit per clock,
//   with a start/busy/done handshake.
//   Ports:
//     clk          clock, rising edge
//     rst_n        synchronous reset, active-low
//     start        request, honoured only in IDLE or DONE
//     dividend     [DIVIDEND_W-1:0] captured on accept
//     divisor      [DIVISOR_W-1:0]  captured on accept
//     busy         high while in RUN
//     done         one-cycle pulse, results valid from this cycle
//     quotient     [DIVIDEND_W-1:0] held until replaced by the next result
//     remainder    [DIVISOR_W-1:0]  held until replaced by the next result
//     div_by_zero  high with done when the captured divisor was zero
//   Build option:
//     DIV_EARLY_EXIT_EN  when defined, dividend < divisor finishes one cycle
//                        after accept instead of running all DIVIDEND_W steps.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start
//   RUN   | iterating steps (or single-cycle short path: /0, early exit)
//   DONE  | done pulse cycle; start here is accepted like in IDLE
module divisor_secuencial
    import divisor_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = cnt_width(DIVIDEND_W);

    state_t                state;
    logic [DIVISOR_W:0]    p_reg;
    logic [DIVIDEND_W-1:0] q_reg;
    logic [DIVISOR_W-1:0]  d_reg;
    logic [CNT_W-1:0]      cnt;
    logic                  short_op;

    logic [DIVISOR_W:0]    p_nxt;
    logic [DIVIDEND_W-1:0] q_nxt;
    logic                  accept_short;

    div_paso #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W)
    ) u_paso (
        .p_in    (p_reg),
        .q_in    (q_reg),
        .divisor (d_reg),
        .p_out   (p_nxt),
        .q_out   (q_nxt)
    );

    // Operations that skip the iteration and finish on the edge after accept.
`ifdef DIV_EARLY_EXIT_EN
    always_comb begin
        accept_short = (divisor == '0) ||
                       ({{(DIVIDEND_W-DIVISOR_W){1'b0}}, divisor} > dividend);
    end
`else
    always_comb begin
        accept_short = (divisor == '0);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            p_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
            short_op    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                    if (start) begin
                        d_reg    <= divisor;
                        p_reg    <= '0;
                        q_reg    <= dividend;
                        cnt      <= '0;
                        short_op <= accept_short;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (short_op) begin
                        // q_reg still holds the untouched dividend here.
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= (d_reg == '0);
                        quotient    <= (d_reg == '0) ? '1 : '0;
                        remainder   <= q_reg[DIVISOR_W-1:0];
                    end else begin
                        p_reg <= p_nxt;
                        q_reg <= q_nxt;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(DIVIDEND_W - 1)) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            quotient  <= q_nxt;
                            remainder <= p_nxt[DIVISOR_W-1:0];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_secuencial.sv
// tb_divisor_secuencial
//   Directed checks of the sequential divider plus a full sweep of all
//   non-zero divisor pairs in a shuffled dividend order.
module tb_divisor_secuencial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam int LAT_SMALL = 1;
`else
    localparam int LAT_SMALL = 8;
`endif

    divisor_secuencial dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Accept edge is the first posedge after the call; lat counts edges
    // from accept until done is seen (sampled 1ns after each edge).
    task automatic run_div(input logic [7:0] a, input logic [3:0] b, output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    int lat;
    int off;
    int seen_done;
    logic [7:0] a;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q",    {24'd0, quotient}, 32'd0);
        chk("rst_r",    {28'd0, remainder}, 32'd0);
        chk("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // 200/7
        run_div(8'd200, 4'd7, lat);
        chk("t1_lat", lat, 8);
        chk("t1_q",   {24'd0, quotient}, 32'd28);
        chk("t1_r",   {28'd0, remainder}, 32'd4);
        chk("t1_dbz", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk); #1;
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        chk("t1_hold_q", {24'd0, quotient}, 32'd28);

        // 15/15 and 255/1
        run_div(8'd15, 4'd15, lat);
        chk("t2a_q", {24'd0, quotient}, 32'd1);
        chk("t2a_r", {28'd0, remainder}, 32'd0);
        run_div(8'd255, 4'd1, lat);
        chk("t2b_q", {24'd0, quotient}, 32'd255);
        chk("t2b_r", {28'd0, remainder}, 32'd0);
        chk("t2b_lat", lat, 8);

        // 5/0
        run_div(8'd5, 4'd0, lat);
        chk("t3_lat", lat, 1);
        chk("t3_q",   {24'd0, quotient}, 32'hFF);
        chk("t3_r",   {28'd0, remainder}, 32'd5);
        chk("t3_dbz", {31'd0, div_by_zero}, 32'd1);
        @(posedge clk); #1;
        chk("t3_dbz_clear", {31'd0, div_by_zero}, 32'd0);
        chk("t3_done_clear", {31'd0, done}, 32'd0);

        // 100/3 with a 9/2 start pulse during RUN that must be ignored
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("t4_busy", {31'd0, busy}, 32'd1);
        lat = 0;
        repeat (2) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        dividend = 8'd9;
        divisor  = 4'd2;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat++;
        while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("t4_lat", lat, 8);
        chk("t4_q", {24'd0, quotient}, 32'd33);
        chk("t4_r", {28'd0, remainder}, 32'd1);
        // back-to-back start during the DONE cycle
        run_div(8'd9, 4'd2, lat);
        chk("t4b_lat", lat, 8);
        chk("t4b_q", {24'd0, quotient}, 32'd4);
        chk("t4b_r", {28'd0, remainder}, 32'd1);

        // reset in the middle of RUN
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_q",    {24'd0, quotient}, 32'd0);
        chk("t5_r",    {28'd0, remainder}, 32'd0);
        chk("t5_dbz",  {31'd0, div_by_zero}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        chk("t5_no_done", seen_done, 0);

        // 3/9
        run_div(8'd3, 4'd9, lat);
        chk("t6_lat", lat, LAT_SMALL);
        chk("t6_q", {24'd0, quotient}, 32'd0);
        chk("t6_r", {28'd0, remainder}, 32'd3);

        // sweep all non-zero divisor pairs, dividends in rotated order
        off = $urandom_range(0, 255);
        for (int i = 0; i < 256; i++) begin
            a = 8'((i + off) % 256);
            for (int b = 1; b < 16; b++) begin
                run_div(a, 4'(b), lat);
                chk("sweep_qr", {19'd0, div_by_zero, quotient, remainder},
                    {19'd0, 1'b0, 8'(a / b), 4'(a % b)});
                chk("sweep_inv", {31'd0, (int'(quotient) * b + int'(remainder) == int'(a))
                                          && (int'(remainder) < b)}, 32'd1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
